// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl - sequencer for a registered 3-to-8 active-low LED decoder.
//
// Modes: blank (IDLE), debounced manual switch (MANUAL), or automatic chase
// (UP, DOWN, BOUNCE) paced by a DIV-cycle prescaler.
//
// Build option: define LED_SEQ_PAUSE_EN to add the pause input, which freezes
// auto-run stepping.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  async reset, active high
//   switch_in  in   3  raw switch code, asynchronous to clk
//   mode       in   3  000 IDLE, 001 MANUAL, 010 UP, 011 DOWN, 100 BOUNCE, others IDLE
//   pause      in   1  (LED_SEQ_PAUSE_EN only) hold auto-run position and phase
//   sel        out  3  decoder select code, registered
//   enable     out  3  decoder enable word (100 active, 000 all off), registered
//   tick       out  1  one-cycle step strobe, registered
module led_seq_ctrl #(
  parameter int DIV        = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] switch_in,
  input  logic [2:0] mode,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] sel,
  output logic [2:0] enable,
  output logic       tick
);

  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MANUAL = 3'd1,
    S_UP     = 3'd2,
    S_DOWN   = 3'd3,
    S_BOUNCE = 3'd4
  } state_t;

  function automatic state_t decode(input logic [2:0] m);
    case (m)
      3'b001:  decode = S_MANUAL;
      3'b010:  decode = S_UP;
      3'b011:  decode = S_DOWN;
      3'b100:  decode = S_BOUNCE;
      default: decode = S_IDLE;
    endcase
  endfunction

  logic pause_w;
`ifdef LED_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // ---------------- switch synchronizer + debounce ----------------
  logic [2:0]    s1_q, s2_q, stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 3'd0;
      s2_q     <= 3'd0;
      stable_q <= 3'd0;
      cnt_q    <= '0;
    end else begin
      s1_q <= switch_in;
      s2_q <= s1_q;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CMAX) begin
        // DEB_CYCLES-th consecutive mismatch: accept the new code
        stable_q <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // ---------------- mode FSM, prescaler, position ----------------
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [2:0]    sel_q, en_q;
  logic          tick_q, dir_q;   // dir_q: 0 = up, 1 = down

  assign state_d = decode(mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sel_q   <= 3'd0;
      en_q    <= 3'b000;
      tick_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == S_IDLE) ? 3'b000 : 3'b100;
      tick_q  <= 1'b0;
      if (state_d != state_q) begin
        // Entry edge: load start position, restart phase; never steps here.
        presc_q <= '0;
        case (state_d)
          S_MANUAL: sel_q <= stable_q;
          S_UP:     sel_q <= 3'd0;
          S_DOWN:   sel_q <= 3'd7;
          S_BOUNCE: begin
            sel_q <= 3'd0;
            dir_q <= 1'b0;
          end
          default: ;  // IDLE keeps the last position
        endcase
      end else begin
        case (state_q)
          S_MANUAL: sel_q <= stable_q;
          S_UP, S_DOWN, S_BOUNCE: begin
            if (!pause_w) begin
              if (presc_q == PMAX) begin
                presc_q <= '0;
                tick_q  <= 1'b1;
                case (state_q)
                  S_UP:   sel_q <= sel_q + 3'd1;
                  S_DOWN: sel_q <= sel_q - 3'd1;
                  default: begin
                    // Ping-pong: endpoints appear once per turn.
                    if (!dir_q && sel_q == 3'd7) begin
                      dir_q <= 1'b1;
                      sel_q <= 3'd6;
                    end else if (dir_q && sel_q == 3'd0) begin
                      dir_q <= 1'b0;
                      sel_q <= 3'd1;
                    end else begin
                      sel_q <= dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
                    end
                  end
                endcase
              end else begin
                presc_q <= presc_q + 1'b1;
              end
            end
          end
          default: presc_q <= '0;
        endcase
      end
    end
  end

  assign sel    = sel_q;
  assign enable = en_q;
  assign tick   = tick_q;

endmodule
